// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus arbiter.
// The producer drives the master modport. The arbiter uses the slave modport.
interface cdb_arbiter_if #(
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32
);
  logic [2:0]          src_valid;
  logic [ROB_ID_W-1:0] src_rob_id [3];
  logic [DATA_W-1:0]   src_data   [3];
  logic [2:0]          src_ready;

  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_data;
  logic [1:0]          cdb_src;

  modport master (
    output src_valid, src_rob_id, src_data,
    input  src_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_src
  );

  modport slave (
    input  src_valid, src_rob_id, src_data,
    output src_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three per-source result FIFOs arbitrated onto one registered CDB.
// Define CDB_FIXED_PRIO_EN for fixed priority (src1 > src0 > src2). The default build uses round-robin.
module cdb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned NSRC = 3;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned EW   = ROB_ID_W + DATA_W;

  logic [EW-1:0]       mem_q    [NSRC][DEPTH];
  logic [PW-1:0]       wr_ptr_q [NSRC];
  logic [PW-1:0]       wr_ptr_d [NSRC];
  logic [PW-1:0]       rd_ptr_q [NSRC];
  logic [PW-1:0]       rd_ptr_d [NSRC];

  logic                cdb_valid_q,  cdb_valid_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_W-1:0]   cdb_data_q,   cdb_data_d;
  logic [1:0]          cdb_src_q,    cdb_src_d;

  logic [NSRC-1:0]     full, empty, ready, push, pop;
  logic [3:0]          cand;
  logic                act;
  logic                gnt_vld;
  logic [1:0]          gnt_idx;
  logic [EW-1:0]       head;

  assign act = rdy & ~clear;

  // The extra pointer bit tells full from empty when the address bits match.
  always_comb begin
    for (int unsigned k = 0; k < NSRC; k++) begin
      empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
      full[k]  = (wr_ptr_q[k] == {~rd_ptr_q[k][PW-1], rd_ptr_q[k][AW-1:0]});
      ready[k] = ~full[k] & act;
      push[k]  = bus.src_valid[k] & ready[k];
    end
  end

  assign cand          = {1'b0, ~empty};
  assign bus.src_ready = ready;

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b1;
    gnt_idx = 2'd0;
    if (cand[1])      gnt_idx = 2'd1;
    else if (cand[0]) gnt_idx = 2'd0;
    else if (cand[2]) gnt_idx = 2'd2;
    else              gnt_vld = 1'b0;
  end
`else
  logic [1:0] rr_q, rr_d;
  logic [1:0] c0, c1, c2;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  always_comb begin
    c0      = rr_q;
    c1      = inc3(c0);
    c2      = inc3(c1);
    gnt_vld = 1'b1;
    gnt_idx = 2'd0;
    if (cand[c0])      gnt_idx = c0;
    else if (cand[c1]) gnt_idx = c1;
    else if (cand[c2]) gnt_idx = c2;
    else               gnt_vld = 1'b0;
  end

  always_comb begin
    rr_d = rr_q;
    if (rdy) begin
      if (clear)        rr_d = '0;
      else if (gnt_vld) rr_d = inc3(gnt_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= '0;
    else      rr_q <= rr_d;
  end
`endif

  assign head = mem_q[gnt_idx][rd_ptr_q[gnt_idx][AW-1:0]];

  always_comb begin
    pop = '0;
    if (gnt_vld && act) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    for (int unsigned k = 0; k < NSRC; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      if (rdy && clear) begin
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
      end else begin
        if (push[k]) wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
        if (pop[k])  rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
      end
    end
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    if (rdy) begin
      if (clear) begin
        cdb_valid_d = 1'b0;
      end else begin
        cdb_valid_d = gnt_vld;
        if (gnt_vld) begin
          cdb_rob_id_d = head[EW-1:DATA_W];
          cdb_data_d   = head[DATA_W-1:0];
          cdb_src_d    = gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= '0;
    end else begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
      end
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k][AW-1:0]] <= {bus.src_rob_id[k], bus.src_data[k]};
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_data   = cdb_data_q;
  assign bus.cdb_src    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table plus hand-written multi-cycle sequences.
// Expected values are hand-derived for the default round-robin build, with CDB_FIXED_PRIO_EN alternatives.
module tb_cdb_arbiter;
  logic clk;
  logic rst;
  logic rdy;
  logic clear;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  cdb_arbiter_if #(.ROB_ID_W(4), .DATA_W(32)) bus ();

  cdb_arbiter #(.DEPTH(4), .ROB_ID_W(4), .DATA_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .clear(clear),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, expected $finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       r;
    logic       c;
    logic [2:0] v;
    logic [11:0] tags;
    logic [2:0] er;
    logic       ev;
    logic [3:0] et;
    logic [1:0] es;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [31:0] dat(input int unsigned k, input logic [3:0] t);
    return 32'hC0DE_0000 | (32'(k) << 8) | 32'(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic [2:0] v, input logic [11:0] tags);
    rdy           = r;
    clear         = c;
    bus.src_valid = v;
    for (int k = 0; k < 3; k++) begin
      bus.src_rob_id[k] = tags[k*4 +: 4];
      bus.src_data[k]   = dat(k, tags[k*4 +: 4]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cdb(input string nm, input logic v, input logic [3:0] t, input logic [1:0] s);
    chk({nm, ".valid"}, 32'(bus.cdb_valid), 32'(v));
    if (v) begin
      chk({nm, ".tag"},  32'(bus.cdb_rob_id), 32'(t));
      chk({nm, ".src"},  32'(bus.cdb_src),    32'(s));
      chk({nm, ".data"}, bus.cdb_data,        dat(s, t));
    end
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, 3'b000, 12'h000);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] n0, n1;
    logic       er0, er1;

    rst = 1'b0;
    drive(1'b1, 1'b0, 3'b000, 12'h000);
    tick;
    chk("rst.valid", 32'(bus.cdb_valid),  32'd0);
    chk("rst.tag",   32'(bus.cdb_rob_id), 32'd0);
    chk("rst.data",  bus.cdb_data,        32'd0);
    chk("rst.src",   32'(bus.cdb_src),    32'd0);
    chk("rst.ready", 32'(bus.src_ready),  32'b111);
    rst = 1'b1;
    #1;

    // single push, one cycle latency, one-cycle pulse
    drive(1'b1, 1'b0, 3'b001, 12'h003);
    bus.src_data[0] = 32'h0000_1234;
    tick;
    chk("t1.e0.valid", 32'(bus.cdb_valid), 32'd0);
    drive(1'b1, 1'b0, 3'b000, 12'h000);
    tick;
    chk("t1.e1.valid", 32'(bus.cdb_valid),  32'd1);
    chk("t1.e1.tag",   32'(bus.cdb_rob_id), 32'd3);
    chk("t1.e1.data",  bus.cdb_data,        32'h0000_1234);
    chk("t1.e1.src",   32'(bus.cdb_src),    32'd0);
    tick;
    chk("t1.e2.valid", 32'(bus.cdb_valid), 32'd0);

    tbl[0]  = '{1'b1, 1'b0, 3'b111, 12'h321, 3'b111, 1'b0, 4'd0,  2'd0};
`ifdef CDB_FIXED_PRIO_EN
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b1, 4'd2,  2'd1};
    tbl[2]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b1, 4'd1,  2'd0};
`else
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b1, 4'd1,  2'd0};
    tbl[2]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b1, 4'd2,  2'd1};
`endif
    tbl[3]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b1, 4'd3,  2'd2};
    tbl[4]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b0, 4'd0,  2'd0};
    tbl[5]  = '{1'b1, 1'b0, 3'b101, 12'h506, 3'b111, 1'b0, 4'd0,  2'd0};
    tbl[6]  = '{1'b1, 1'b0, 3'b010, 12'h070, 3'b111, 1'b1, 4'd6,  2'd0};
    tbl[7]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b1, 4'd7,  2'd1};
    tbl[8]  = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b1, 4'd5,  2'd2};
    tbl[9]  = '{1'b1, 1'b1, 3'b001, 12'h009, 3'b000, 1'b0, 4'd0,  2'd0};
    tbl[10] = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b0, 4'd0,  2'd0};
    tbl[11] = '{1'b0, 1'b0, 3'b010, 12'h0A0, 3'b000, 1'b0, 4'd0,  2'd0};
    tbl[12] = '{1'b1, 1'b0, 3'b000, 12'h000, 3'b111, 1'b0, 4'd0,  2'd0};

    do_reset;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].tags);
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(bus.src_ready), 32'(tbl[i].er));
      tick;
      chk_cdb($sformatf("vec%0d", i), tbl[i].ev, tbl[i].et, tbl[i].es);
    end

    // src1 alone streams 5 results; its FIFO never fills
    do_reset;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, (i < 5) ? 3'b010 : 3'b000, {4'd0, 4'(i + 1), 4'd0});
      #1;
      if (i < 5) chk($sformatf("s1only%0d.ready1", i), 32'(bus.src_ready[1]), 32'd1);
      tick;
      if (i >= 1 && i <= 5) chk_cdb($sformatf("s1only%0d", i), 1'b1, 4'(i), 2'd1);
      else                  chk_cdb($sformatf("s1only%0d", i), 1'b0, 4'd0, 2'd0);
    end

`ifndef CDB_FIXED_PRIO_EN
    // src0 and src1 saturate: grants alternate, each FIFO fills to 4 in turn
    do_reset;
    n0 = 4'd1;
    n1 = 4'd1;
    for (int j = 0; j <= 16; j++) begin
      drive(1'b1, 1'b0, (j <= 8) ? 3'b011 : 3'b000, {4'd0, n1, n0});
      #1;
      er0 = (j != 7);
      er1 = !(j == 6 || j == 8);
      if (j <= 8) begin
        chk($sformatf("sat%0d.ready", j), 32'(bus.src_ready[1:0]), 32'({er1, er0}));
        if (er0) n0 = n0 + 4'd1;
        if (er1) n1 = n1 + 4'd1;
      end
      tick;
      if (j == 0 || j == 16)  chk_cdb($sformatf("sat%0d", j), 1'b0, 4'd0, 2'd0);
      else if (j % 2 == 1)    chk_cdb($sformatf("sat%0d", j), 1'b1, 4'((j + 1) / 2), 2'd0);
      else                    chk_cdb($sformatf("sat%0d", j), 1'b1, 4'(j / 2), 2'd1);
    end
`endif

    // flush with backlog in every FIFO plus a same-cycle push
    do_reset;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b0, 3'b111, {4'(9 + j), 4'(1 + j), 4'(4 + j)});
      tick;
`ifdef CDB_FIXED_PRIO_EN
      if (j == 0) chk_cdb("flush.e0", 1'b0, 4'd0, 2'd0);
      else        chk_cdb($sformatf("flush.e%0d", j), 1'b1, 4'(j), 2'd1);
`else
      case (j)
        1:       chk_cdb("flush.e1", 1'b1, 4'd4, 2'd0);
        2:       chk_cdb("flush.e2", 1'b1, 4'd1, 2'd1);
        3:       chk_cdb("flush.e3", 1'b1, 4'd9, 2'd2);
        default: chk_cdb("flush.e0", 1'b0, 4'd0, 2'd0);
      endcase
`endif
    end
    drive(1'b1, 1'b1, 3'b001, 12'h008);
    #1;
    chk("flush.clr.ready", 32'(bus.src_ready), 32'b000);
    tick;
    chk_cdb("flush.clr", 1'b0, 4'd0, 2'd0);
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b0, 3'b000, 12'h000);
      #1;
      chk($sformatf("flush.post%0d.ready", j), 32'(bus.src_ready), 32'b111);
      tick;
      chk_cdb($sformatf("flush.post%0d", j), 1'b0, 4'd0, 2'd0);
    end

    // rdy low freezes a valid broadcast and blocks pushes; arbitration resumes afterwards
    do_reset;
    drive(1'b1, 1'b0, 3'b111, 12'h321);
    tick;
    chk_cdb("frz.e0", 1'b0, 4'd0, 2'd0);
    drive(1'b1, 1'b0, 3'b000, 12'h000);
    tick;
`ifdef CDB_FIXED_PRIO_EN
    chk_cdb("frz.e1", 1'b1, 4'd2, 2'd1);
`else
    chk_cdb("frz.e1", 1'b1, 4'd1, 2'd0);
`endif
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 3'b111, 12'hFED);
      #1;
      chk($sformatf("frz.hold%0d.ready", j), 32'(bus.src_ready), 32'b000);
      tick;
`ifdef CDB_FIXED_PRIO_EN
      chk_cdb($sformatf("frz.hold%0d", j), 1'b1, 4'd2, 2'd1);
`else
      chk_cdb($sformatf("frz.hold%0d", j), 1'b1, 4'd1, 2'd0);
`endif
    end
    drive(1'b1, 1'b0, 3'b000, 12'h000);
    tick;
`ifdef CDB_FIXED_PRIO_EN
    chk_cdb("frz.r0", 1'b1, 4'd1, 2'd0);
`else
    chk_cdb("frz.r0", 1'b1, 4'd2, 2'd1);
`endif
    tick;
    chk_cdb("frz.r1", 1'b1, 4'd3, 2'd2);
    tick;
    chk_cdb("frz.r2", 1'b0, 4'd0, 2'd0);

    // asynchronous reset between clock edges while a broadcast is valid
    do_reset;
    drive(1'b1, 1'b0, 3'b100, 12'h600);
    tick;
    chk_cdb("arst.e0", 1'b0, 4'd0, 2'd0);
    drive(1'b1, 1'b0, 3'b000, 12'h000);
    tick;
    chk_cdb("arst.e1", 1'b1, 4'd6, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.valid", 32'(bus.cdb_valid),  32'd0);
    chk("arst.tag",   32'(bus.cdb_rob_id), 32'd0);
    chk("arst.data",  bus.cdb_data,        32'd0);
    chk("arst.src",   32'(bus.cdb_src),    32'd0);
    chk("arst.ready", 32'(bus.src_ready),  32'b111);
    rst = 1'b1;
    tick;
    chk_cdb("arst.after", 1'b0, 4'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
